dispatch_rename_unit: RTL and testbench
=======================================

# dispatch_rename_unit

Parametrised N-wide in-order instruction dispatch and register-renaming unit. Each cycle it accepts up to ISSUE_W decoded instructions and allocates a free reservation station of the matching class. It renames destination registers in a register status table and resolves source operands to producer tags. Common-data-bus (CDB) broadcasts free stations and clear register status. It sits between the fetch/decode queue and the reservation stations.

## Interface
- ISSUE_W, 2: instructions examined per cycle (1..4).
- RS_PER_CLASS, 2: stations per class; classes are ADD, MULT, MEM (LOAD and STORE share MEM).
- NUM_REG, 8: architectural registers; power of two.
- INS_PART_WID, 4: width of type/dest/src fields.
- TAG_LEN, 4: tag width; must satisfy 2^TAG_LEN > 3*RS_PER_CLASS.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_valid  in  ISSUE_W  per-slot instruction present.
- inst_type / inst_dest / inst_src0 / inst_src1  in  ISSUE_W*INS_PART_WID each  slot i at bits [i*W +: W].
- inst_fetch  out  ISSUE_W  combinational; slot accepted this cycle.
- disp_valid  out  ISSUE_W  registered dispatch strobe.
- disp_rs_tag / disp_src0_tag / disp_src1_tag  out  ISSUE_W*TAG_LEN each  allocated station; producer tag per source (0 = read register file).
- disp_src0_reg / disp_src1_reg  out  ISSUE_W*INS_PART_WID each  source register indices passed through.
- cdb_valid  in  1  broadcast present.
- cdb_tag  in  TAG_LEN  completing station tag.
- illegal_op  out  1  registered; pulses one cycle per cycle containing an accepted unknown opcode.

## Operation
- Opcodes: 0001 ADD, 0010 MULT, 0011 LOAD, 0100 STORE; all others illegal.
- Tag encoding: tag = class*RS_PER_CLASS + index + 1 (ADD=0, MULT=1, MEM=2); tag 0 is reserved for "ready".
- State: rs_busy bit per station; reg_status[NUM_REG] holds a TAG_LEN tag, nonzero meaning busy.
- Allocation: lowest-index free station of the class. In-order: slot i is accepted only if inst_valid[i] and all slots < i are accepted, and a station is available after slots < i have claimed theirs in the same cycle.
- Source lookup per slot: the youngest earlier slot in the same bundle writing that register supplies its tag. Otherwise reg_status is used. A lookup result equal to cdb_tag with cdb_valid high is forced to 0.
- Dest rename: ADD, MULT and LOAD write their station tag to reg_status[dest]. STORE does not rename. For WAW within a bundle, the highest slot wins.
- CDB: clears rs_busy[cdb_tag]. Clears reg_status[r] only where the entry equals cdb_tag and no slot renames r this cycle; a same-cycle rename wins. A cdb_tag of 0 or out of range is ignored.
- Illegal opcode: accepted, consumes no station, disp_valid stays 0, illegal_op is set.
- Dest/src fields index with their low log2(NUM_REG) bits.

## Timing
- inst_fetch is combinational from the current state, the inst_* inputs and the CDB (when bypassed).
- State updates on the rising clk edge. disp_* and illegal_op are registered: latency is 1 cycle from acceptance.
- Reset: all rs_busy and reg_status entries 0. disp_valid, disp_* and illegal_op are 0; inst_fetch then reflects the empty state combinationally.
- Reset asserted mid-operation discards any accepted bundle; no dispatch appears the next cycle.
- Full class: the slot stalls (inst_fetch=0), and every younger slot stalls too.

## Configuration
- DISPATCH_CDB_FREE_BYPASS_EN defined: a station freed by the CDB this cycle is allocatable in the same cycle.
- DISPATCH_CDB_FREE_BYPASS_EN undefined: a freed station is allocatable from the next cycle.
- Source-tag CDB forwarding is always on in both builds.

## Structure
- dispatch_pkg: opcode constants, class enumeration, tag-encode function and reserved tag 0.
- Sub-module rs_alloc: per-class priority allocator taking busy bits and claims from earlier slots, returning a grant and index. One instance per slot per class.

## Test plan
- Reset, then ADD r1<-r2,r3 in slot 0 -> inst_fetch=01; next cycle disp_rs_tag=1, src tags 0; reg_status[1]=1.
- Bundle ADD r4<-r1,r2 ; MULT r5<-r4,r4 with empty tables -> slot 1 src tags both equal slot 0 tag 1; rs tags 1 and 3.
- Three ADDs across 2 cycles with RS_PER_CLASS=2 and no CDB -> third stalls, slot 1 in its bundle is blocked; cdb_tag=1 releases it next cycle, or the same cycle with the bypass macro.
- LOAD r2 in flight (tag 5); cdb_tag=5 in the same cycle as an ADD reading r2 -> disp_src0_tag=0 and reg_status[2] cleared.
- Rename r3 to tag 1, then re-rename r3 to tag 2; CDB tag 1 -> reg_status[3] stays 2.
- Opcode 0111 in slot 0 -> accepted, disp_valid[0]=0, illegal_op=1 for one cycle; no station consumed.

Source files
------------

// File: rtl/dispatch_pkg.sv
// ---------------------------------------------------------------------------
// dispatch_pkg: opcodes, station classes and tag encoding for dispatch/rename.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dispatch_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_MULT  = 4'b0010;
   localparam logic [3:0] OP_LOAD  = 4'b0011;
   localparam logic [3:0] OP_STORE = 4'b0100;

   localparam int NUM_CLASS = 3;
   localparam int TAG_READY = 0;

   typedef enum logic [1:0] {
      CLS_ADD  = 2'd0,
      CLS_MULT = 2'd1,
      CLS_MEM  = 2'd2,
      CLS_NONE = 2'd3
   } rs_class_e;

   // Tag 0 stays reserved for "operand ready", hence the +1.
   function automatic int encode_tag(input int cls, input int idx, input int rs_per_class);
      return cls * rs_per_class + idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rs_alloc.sv
// ---------------------------------------------------------------------------
// rs_alloc: lowest-index free station picker for one class, one issue slot.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs_alloc #(
   parameter int RS_PER_CLASS = 2,
   parameter int IDX_W        = 1
) (
   input  logic                    req,
   input  logic [RS_PER_CLASS-1:0] busy,
   input  logic [RS_PER_CLASS-1:0] claimed,
   output logic                    grant,
   output logic [IDX_W-1:0]        idx,
   output logic [RS_PER_CLASS-1:0] onehot
);

   logic [RS_PER_CLASS-1:0] free_mask;
   logic                    any_free;

   assign free_mask = ~(busy | claimed);

   always_comb begin
      any_free = 1'b0;
      idx      = '0;
      onehot   = '0;
      for (int k = 0; k < RS_PER_CLASS; k++) begin
         if (free_mask[k] && !any_free) begin
            any_free  = 1'b1;
            idx       = IDX_W'(k);
            onehot[k] = req;
         end
      end
   end

   assign grant = req && any_free;

endmodule

`default_nettype wire

// File: rtl/dispatch_rename_unit.sv
// ---------------------------------------------------------------------------
// dispatch_rename_unit: N-wide in-order dispatch with station allocation and
// register renaming. Option macro: DISPATCH_CDB_FREE_BYPASS_EN. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dispatch_rename_unit
   import dispatch_pkg::*;
#(
   parameter int ISSUE_W      = 2,
   parameter int RS_PER_CLASS = 2,
   parameter int NUM_REG      = 8,
   parameter int INS_PART_WID = 4,
   parameter int TAG_LEN      = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ISSUE_W-1:0]              inst_valid,
   input  logic [ISSUE_W*INS_PART_WID-1:0] inst_type,
   input  logic [ISSUE_W*INS_PART_WID-1:0] inst_dest,
   input  logic [ISSUE_W*INS_PART_WID-1:0] inst_src0,
   input  logic [ISSUE_W*INS_PART_WID-1:0] inst_src1,
   output logic [ISSUE_W-1:0]              inst_fetch,
   output logic [ISSUE_W-1:0]              disp_valid,
   output logic [ISSUE_W*TAG_LEN-1:0]      disp_rs_tag,
   output logic [ISSUE_W*TAG_LEN-1:0]      disp_src0_tag,
   output logic [ISSUE_W*TAG_LEN-1:0]      disp_src1_tag,
   output logic [ISSUE_W*INS_PART_WID-1:0] disp_src0_reg,
   output logic [ISSUE_W*INS_PART_WID-1:0] disp_src1_reg,
   input  logic                            cdb_valid,
   input  logic [TAG_LEN-1:0]              cdb_tag,
   output logic                            illegal_op
);

   localparam int NUM_RS = NUM_CLASS * RS_PER_CLASS;
   localparam int REG_W  = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
   localparam int IDX_W  = (RS_PER_CLASS > 1) ? $clog2(RS_PER_CLASS) : 1;

   logic [NUM_RS-1:0]  rs_busy;
   logic [NUM_RS-1:0]  rs_busy_nxt;
   logic [NUM_RS-1:0]  busy_eff;
   logic [NUM_RS-1:0]  cdb_free;
   logic               cdb_hit;
   logic [TAG_LEN-1:0] reg_status     [NUM_REG];
   logic [TAG_LEN-1:0] reg_status_nxt [NUM_REG];

   logic [ISSUE_W-1:0]              slot_legal;
   logic [ISSUE_W-1:0]              slot_renames;
   logic [ISSUE_W-1:0][TAG_LEN-1:0] slot_tag;
   logic [ISSUE_W-1:0][TAG_LEN-1:0] src0_tag;
   logic [ISSUE_W-1:0][TAG_LEN-1:0] src1_tag;
   logic                            unused_dest_bits;

   assign unused_dest_bits = ^inst_dest;

   // One-hot station being released by the CDB; tag 0 and out-of-range tags match nothing.
   always_comb begin
      cdb_free = '0;
      for (int s = 0; s < NUM_RS; s++) begin
         cdb_free[s] = cdb_valid && (cdb_tag == TAG_LEN'(s + 1));
      end
   end
   assign cdb_hit = |cdb_free;

`ifdef DISPATCH_CDB_FREE_BYPASS_EN
   assign busy_eff = rs_busy & ~cdb_free;
`else
   assign busy_eff = rs_busy;
`endif

   for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
      logic [INS_PART_WID-1:0]            op;
      rs_class_e                          cls;
      logic                               legal;
      logic                               renames;
      logic                               ok;
      logic                               prev_ok;
      logic [NUM_RS-1:0]                  claim_in;
      logic [NUM_RS-1:0]                  claim_out;
      logic [NUM_CLASS-1:0]               grant_v;
      logic [NUM_CLASS-1:0][IDX_W-1:0]    idx_v;
      logic                               grant_sel;
      logic [IDX_W-1:0]                   idx_sel;

      // Stations claimed and acceptance ripple from older slots to younger ones.
      if (i == 0) begin : g_head
         assign claim_in = '0;
         assign prev_ok  = 1'b1;
      end else begin : g_chain
         assign claim_in = g_slot[i-1].claim_out;
         assign prev_ok  = g_slot[i-1].ok;
      end

      assign op = inst_type[i*INS_PART_WID +: INS_PART_WID];

      always_comb begin
         cls = CLS_NONE;
         if (op == INS_PART_WID'(OP_ADD)) begin
            cls = CLS_ADD;
         end else if (op == INS_PART_WID'(OP_MULT)) begin
            cls = CLS_MULT;
         end else if (op == INS_PART_WID'(OP_LOAD) || op == INS_PART_WID'(OP_STORE)) begin
            cls = CLS_MEM;
         end
      end

      assign legal   = (cls != CLS_NONE);
      assign renames = legal && (op != INS_PART_WID'(OP_STORE));

      for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cls
         logic [RS_PER_CLASS-1:0] onehot;

         rs_alloc #(
            .RS_PER_CLASS (RS_PER_CLASS),
            .IDX_W        (IDX_W)
         ) u_alloc (
            .req     (cls == rs_class_e'(c)),
            .busy    (busy_eff[c*RS_PER_CLASS +: RS_PER_CLASS]),
            .claimed (claim_in[c*RS_PER_CLASS +: RS_PER_CLASS]),
            .grant   (grant_v[c]),
            .idx     (idx_v[c]),
            .onehot  (onehot)
         );

         assign claim_out[c*RS_PER_CLASS +: RS_PER_CLASS] =
            claim_in[c*RS_PER_CLASS +: RS_PER_CLASS] | ({RS_PER_CLASS{ok}} & onehot);
      end

      always_comb begin
         grant_sel = 1'b0;
         idx_sel   = '0;
         case (cls)
            CLS_ADD:  begin grant_sel = grant_v[0]; idx_sel = idx_v[0]; end
            CLS_MULT: begin grant_sel = grant_v[1]; idx_sel = idx_v[1]; end
            CLS_MEM:  begin grant_sel = grant_v[2]; idx_sel = idx_v[2]; end
            default:  begin grant_sel = 1'b0;       idx_sel = '0;       end
         endcase
      end

      // Illegal opcodes need no station, so they never stall.
      assign ok            = inst_valid[i] && prev_ok && (!legal || grant_sel);
      assign inst_fetch[i] = ok;
      assign slot_legal[i]   = legal;
      assign slot_renames[i] = renames;
      assign slot_tag[i]     = legal ? TAG_LEN'(encode_tag(int'(cls), int'(idx_sel), RS_PER_CLASS))
                                     : TAG_LEN'(TAG_READY);
   end

   // Source resolution: youngest older in-bundle writer, else table, then CDB forwarding.
   always_comb begin
      logic [REG_W-1:0]   r0;
      logic [REG_W-1:0]   r1;
      logic [REG_W-1:0]   rd;
      logic [TAG_LEN-1:0] t0;
      logic [TAG_LEN-1:0] t1;
      src0_tag = '0;
      src1_tag = '0;
      r0 = '0;
      r1 = '0;
      rd = '0;
      t0 = '0;
      t1 = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         r0 = inst_src0[i*INS_PART_WID +: REG_W];
         r1 = inst_src1[i*INS_PART_WID +: REG_W];
         t0 = reg_status[r0];
         t1 = reg_status[r1];
         for (int j = 0; j < i; j++) begin
            rd = inst_dest[j*INS_PART_WID +: REG_W];
            if (inst_fetch[j] && slot_renames[j]) begin
               if (rd == r0) t0 = slot_tag[j];
               if (rd == r1) t1 = slot_tag[j];
            end
         end
         if (cdb_valid && t0 == cdb_tag) t0 = TAG_LEN'(TAG_READY);
         if (cdb_valid && t1 == cdb_tag) t1 = TAG_LEN'(TAG_READY);
         src0_tag[i] = t0;
         src1_tag[i] = t1;
      end
   end

   // CDB clear first, then renames in slot order so the youngest writer wins.
   always_comb begin
      logic [REG_W-1:0] wd;
      wd = '0;
      for (int r = 0; r < NUM_REG; r++) begin
         reg_status_nxt[r] = reg_status[r];
         if (cdb_hit && reg_status[r] == cdb_tag) reg_status_nxt[r] = TAG_LEN'(TAG_READY);
      end
      for (int j = 0; j < ISSUE_W; j++) begin
         wd = inst_dest[j*INS_PART_WID +: REG_W];
         if (inst_fetch[j] && slot_renames[j]) reg_status_nxt[wd] = slot_tag[j];
      end
   end

   assign rs_busy_nxt = (rs_busy & ~cdb_free) | g_slot[ISSUE_W-1].claim_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         rs_busy       <= '0;
         disp_valid    <= '0;
         disp_rs_tag   <= '0;
         disp_src0_tag <= '0;
         disp_src1_tag <= '0;
         disp_src0_reg <= '0;
         disp_src1_reg <= '0;
         illegal_op    <= 1'b0;
         for (int r = 0; r < NUM_REG; r++) begin
            reg_status[r] <= '0;
         end
      end else begin
         rs_busy       <= rs_busy_nxt;
         disp_valid    <= inst_fetch & slot_legal;
         disp_rs_tag   <= slot_tag;
         disp_src0_tag <= src0_tag;
         disp_src1_tag <= src1_tag;
         disp_src0_reg <= inst_src0;
         disp_src1_reg <= inst_src1;
         illegal_op    <= |(inst_fetch & ~slot_legal);
         for (int r = 0; r < NUM_REG; r++) begin
            reg_status[r] <= reg_status_nxt[r];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_rename_unit.sv
// ---------------------------------------------------------------------------
// tb_dispatch_rename_unit: directed self-checking bench for dispatch_rename_unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dispatch_rename_unit;

   localparam int IW = 2;
   localparam int W  = 4;
   localparam int TL = 4;

   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_MULT  = 4'b0010;
   localparam logic [3:0] OP_LOAD  = 4'b0011;
   localparam logic [3:0] OP_BAD   = 4'b0111;

   logic            clk = 1'b0;
   logic            rst;
   logic [IW-1:0]   inst_valid;
   logic [IW*W-1:0] inst_type, inst_dest, inst_src0, inst_src1;
   logic [IW-1:0]   inst_fetch;
   logic [IW-1:0]   disp_valid;
   logic [IW*TL-1:0] disp_rs_tag, disp_src0_tag, disp_src1_tag;
   logic [IW*W-1:0] disp_src0_reg, disp_src1_reg;
   logic            cdb_valid;
   logic [TL-1:0]   cdb_tag;
   logic            illegal_op;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dispatch_rename_unit dut (
      .clk           (clk),
      .rst           (rst),
      .inst_valid    (inst_valid),
      .inst_type     (inst_type),
      .inst_dest     (inst_dest),
      .inst_src0     (inst_src0),
      .inst_src1     (inst_src1),
      .inst_fetch    (inst_fetch),
      .disp_valid    (disp_valid),
      .disp_rs_tag   (disp_rs_tag),
      .disp_src0_tag (disp_src0_tag),
      .disp_src1_tag (disp_src1_tag),
      .disp_src0_reg (disp_src0_reg),
      .disp_src1_reg (disp_src1_reg),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .illegal_op    (illegal_op)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_valid = '0;
      inst_type  = '0;
      inst_dest  = '0;
      inst_src0  = '0;
      inst_src1  = '0;
      cdb_valid  = 1'b0;
      cdb_tag    = '0;
   endtask

   task automatic put(input int s, input logic [3:0] t, input logic [3:0] d,
                      input logic [3:0] a, input logic [3:0] b);
      inst_valid[s]      = 1'b1;
      inst_type[s*W +: W] = t;
      inst_dest[s*W +: W] = d;
      inst_src0[s*W +: W] = a;
      inst_src1[s*W +: W] = b;
   endtask

   task automatic cdb(input logic [3:0] t);
      cdb_valid = 1'b1;
      cdb_tag   = t;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_valid", disp_valid, 0);
      check("rst_illegal", illegal_op, 0);
      check("rst_rstag", disp_rs_tag, 0);
      check("rst_fetch", inst_fetch, 0);

      // Single ADD r1 <- r2, r3
      put(0, OP_ADD, 4'd1, 4'd2, 4'd3);
      #1 check("a_fetch", inst_fetch, 2'b01);
      tick();
      check("a_valid", disp_valid, 2'b01);
      check("a_rstag", disp_rs_tag[3:0], 1);
      check("a_src0t", disp_src0_tag[3:0], 0);
      check("a_src1t", disp_src1_tag[3:0], 0);
      check("a_src0r", disp_src0_reg[3:0], 2);
      check("a_src1r", disp_src1_reg[3:0], 3);
      check("a_illegal", illegal_op, 0);
      idle();
      put(0, OP_MULT, 4'd6, 4'd1, 4'd0);
      #1 check("a2_fetch", inst_fetch, 2'b01);
      tick();
      check("a2_rstag", disp_rs_tag[3:0], 3);
      check("a2_src0t", disp_src0_tag[3:0], 1);
      check("a2_src1t", disp_src1_tag[3:0], 0);

      // In-bundle forwarding, then WAW inside a bundle
      do_reset();
      put(0, OP_ADD, 4'd4, 4'd1, 4'd2);
      put(1, OP_MULT, 4'd5, 4'd4, 4'd4);
      #1 check("b_fetch", inst_fetch, 2'b11);
      tick();
      check("b_valid", disp_valid, 2'b11);
      check("b_rstag0", disp_rs_tag[3:0], 1);
      check("b_rstag1", disp_rs_tag[7:4], 3);
      check("b_s0src0", disp_src0_tag[3:0], 0);
      check("b_s1src0", disp_src0_tag[7:4], 1);
      check("b_s1src1", disp_src1_tag[7:4], 1);
      idle();
      put(0, OP_ADD, 4'd6, 4'd0, 4'd0);
      put(1, OP_MULT, 4'd6, 4'd0, 4'd0);
      #1 check("waw_fetch", inst_fetch, 2'b11);
      tick();
      check("waw_rstag0", disp_rs_tag[3:0], 2);
      check("waw_rstag1", disp_rs_tag[7:4], 4);
      idle();
      put(0, OP_LOAD, 4'd7, 4'd6, 4'd5);
      #1 check("waw2_fetch", inst_fetch, 2'b01);
      tick();
      check("waw2_rstag", disp_rs_tag[3:0], 5);
      check("waw2_src0t", disp_src0_tag[3:0], 4);
      check("waw2_src1t", disp_src1_tag[3:0], 3);

      // Full ADD class stalls the slot and everything younger
      do_reset();
      put(0, OP_ADD, 4'd1, 4'd0, 4'd0);
      put(1, OP_ADD, 4'd2, 4'd0, 4'd0);
      #1 check("c_fetch", inst_fetch, 2'b11);
      tick();
      check("c_rstag1", disp_rs_tag[7:4], 2);
      idle();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      put(1, OP_MULT, 4'd7, 4'd0, 4'd0);
      #1 check("c_stall_fetch", inst_fetch, 2'b00);
      tick();
      check("c_stall_valid", disp_valid, 2'b00);
      idle();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      put(1, OP_MULT, 4'd7, 4'd0, 4'd0);
      cdb(4'd9);
      #1 check("c_oor_fetch", inst_fetch, 2'b00);
      tick();
      idle();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      put(1, OP_MULT, 4'd7, 4'd0, 4'd0);
      cdb(4'd1);
`ifdef DISPATCH_CDB_FREE_BYPASS_EN
      #1 check("c_cdb_fetch", inst_fetch, 2'b11);
      tick();
`else
      #1 check("c_cdb_fetch", inst_fetch, 2'b00);
      tick();
      check("c_cdb_valid", disp_valid, 2'b00);
      idle();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      put(1, OP_MULT, 4'd7, 4'd0, 4'd0);
      #1 check("c_next_fetch", inst_fetch, 2'b11);
      tick();
`endif
      check("c_rel_valid", disp_valid, 2'b11);
      check("c_rel_rstag0", disp_rs_tag[3:0], 1);
      check("c_rel_rstag1", disp_rs_tag[7:4], 3);

      // CDB forwarding to a same-cycle source read
      do_reset();
      put(0, OP_LOAD, 4'd2, 4'd0, 4'd0);
      tick();
      check("d_rstag", disp_rs_tag[3:0], 5);
      idle();
      put(0, OP_ADD, 4'd4, 4'd2, 4'd0);
      cdb(4'd5);
      #1 check("d_fetch", inst_fetch, 2'b01);
      tick();
      check("d_src0t", disp_src0_tag[3:0], 0);
      check("d_rstag2", disp_rs_tag[3:0], 1);
      idle();
      put(0, OP_ADD, 4'd5, 4'd2, 4'd4);
      tick();
      check("d_cleared", disp_src0_tag[3:0], 0);
      check("d_src1t", disp_src1_tag[3:0], 1);
      check("d_rstag3", disp_rs_tag[3:0], 2);

      // Stale CDB tag must not clear a re-renamed register; same-cycle rename wins
      do_reset();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      tick();
      idle();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      tick();
      check("e_rstag", disp_rs_tag[3:0], 2);
      idle();
      cdb(4'd1);
      tick();
      idle();
      put(0, OP_MULT, 4'd0, 4'd3, 4'd3);
      tick();
      check("e_stale", disp_src0_tag[3:0], 2);
      idle();
      put(0, OP_ADD, 4'd3, 4'd0, 4'd0);
      cdb(4'd2);
      #1 check("e2_fetch", inst_fetch, 2'b01);
      tick();
      check("e2_rstag", disp_rs_tag[3:0], 1);
      idle();
      put(0, OP_MULT, 4'd0, 4'd3, 4'd0);
      tick();
      check("e2_renamewins", disp_src0_tag[3:0], 1);

      // Illegal opcode: accepted, no dispatch, one-cycle flag, no rename
      do_reset();
      put(0, OP_BAD, 4'd1, 4'd0, 4'd0);
      put(1, OP_ADD, 4'd2, 4'd0, 4'd0);
      #1 check("f_fetch", inst_fetch, 2'b11);
      tick();
      check("f_valid", disp_valid, 2'b10);
      check("f_illegal", illegal_op, 1);
      check("f_rstag1", disp_rs_tag[7:4], 1);
      idle();
      put(0, OP_MULT, 4'd0, 4'd1, 4'd2);
      tick();
      check("f_illegal_off", illegal_op, 0);
      check("f_norename", disp_src0_tag[3:0], 0);
      check("f_src1t", disp_src1_tag[3:0], 1);

      // Reset asserted with a bundle being accepted discards it
      idle();
      put(0, OP_ADD, 4'd6, 4'd0, 4'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("g_valid", disp_valid, 2'b00);
      idle();
      put(0, OP_ADD, 4'd1, 4'd6, 4'd0);
      tick();
      check("g_rstag", disp_rs_tag[3:0], 1);
      check("g_src0t", disp_src0_tag[3:0], 0);

      idle();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
